// File: rtl/cpu_defs.sv
// Shared CPU definitions for the write-back slice.
//   REG_W / DATA_W      : register index and datapath widths
//   REG_LINK / REG_ZERO : link register and hard-wired zero register
//   wr_req_t            : one GPR write request (enable, destination, data)
//   ext_byte()          : widen a loaded byte, sign- or zero-extended
package cpu_defs;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int NUM_REGS = 1 << REG_W;

   localparam logic [REG_W-1:0] REG_LINK = 5'd31;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic              we;
      logic [REG_W-1:0]  addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sext);
      return {{(DATA_W-8){sext & b[7]}}, b};
   endfunction

endpackage

// File: rtl/wb_regfile.sv
// 32 x DATA_W general-purpose register file.
//   clk, rst     : clock, synchronous active-high clear of every entry
//   wr           : write request, committed on the rising edge when wr.we=1
//   ra1/ra2      : read addresses
//   rd1/rd2      : combinational read data with write-through bypass
// Register 0 reads as zero and is never written.
module wb_regfile
   import cpu_defs::*;
(
   input  logic              clk,
   input  logic              rst,
   input  wr_req_t           wr,
   input  logic [REG_W-1:0]  ra1,
   input  logic [REG_W-1:0]  ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;

   always_ff @(posedge clk) begin
      if (rst)
         regs <= '0;
      else if (wr.we && wr.addr != REG_ZERO)
         regs[wr.addr] <= wr.data;
   end

   // Bypass lets ID see a value being written on the same edge it reads.
   function automatic logic [DATA_W-1:0] rd_port(input logic [REG_W-1:0] ra,
                                                 input wr_req_t w,
                                                 input logic [NUM_REGS-1:0][DATA_W-1:0] r);
      if (ra == REG_ZERO)
         return '0;
      else if (w.we && ra == w.addr)
         return w.data;
      else
         return r[ra];
   endfunction

   assign rd1 = rd_port(ra1, wr, regs);
   assign rd2 = rd_port(ra2, wr, regs);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: consumes the MEM/WR pipeline register outputs, forms the
// GPR write, commits it into the register file and keeps the last committed
// write for the EX forwarding unit.
//   clk, rst             : clock, synchronous active-high reset
//   pc_in, Result_in     : instruction PC and ALU result (Result_in[1:0] = byte lane)
//   dm_read_in           : data-memory read word
//   rt_in, rd_in, RegDst_in, IsLink_in : destination selection
//   MemtoReg_in, IsByteW_in, ExtopM_in : write-data selection / load extension
//   RegWr_in             : instruction writes a GPR
//   ra1, ra2 / rd1, rd2  : ID read ports (bypassed)
//   wb_we/addr/data      : write being committed at the next rising edge
//   fw_valid/addr/data   : last committed write
//   wr_count             : number of committed writes (wraps)
module wb_stage
   import cpu_defs::*;
#(
   parameter int LINK_OFFSET = 4,
   parameter int CNT_W       = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       Result_in,
   input  logic [31:0]       dm_read_in,
   input  logic [4:0]        rt_in,
   input  logic [4:0]        rd_in,
   input  logic              RegDst_in,
   input  logic              MemtoReg_in,
   input  logic              RegWr_in,
   input  logic              ExtopM_in,
   input  logic              IsLink_in,
   input  logic              IsByteW_in,
   input  logic [4:0]        ra1,
   input  logic [4:0]        ra2,
   output logic [31:0]       rd1,
   output logic [31:0]       rd2,
   output logic              wb_we,
   output logic [4:0]        wb_addr,
   output logic [31:0]       wb_data,
   output logic              fw_valid,
   output logic [4:0]        fw_addr,
   output logic [31:0]       fw_data,
   output logic [CNT_W-1:0]  wr_count
);

   logic [7:0]        ld_byte;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] link_data;
   wr_req_t           wr;

   // Little-endian byte lane of the loaded word.
   always_comb begin
      ld_byte = dm_read_in[7:0];
      case (Result_in[1:0])
         2'd0:    ld_byte = dm_read_in[7:0];
         2'd1:    ld_byte = dm_read_in[15:8];
         2'd2:    ld_byte = dm_read_in[23:16];
         default: ld_byte = dm_read_in[31:24];
      endcase
   end

   assign ld_data   = IsByteW_in ? ext_byte(ld_byte, ExtopM_in) : dm_read_in;
   assign link_data = pc_in + DATA_W'(LINK_OFFSET);

   // Link writes override both destination and data selection.
   always_comb begin
      wr.addr = IsLink_in ? REG_LINK : (RegDst_in ? rd_in : rt_in);
      wr.data = IsLink_in ? link_data : (MemtoReg_in ? ld_data : Result_in);
      // rst suppresses the write so an in-flight instruction is dropped.
      wr.we   = RegWr_in & (wr.addr != REG_ZERO) & ~rst;
   end

   assign wb_we   = wr.we;
   assign wb_addr = wr.addr;
   assign wb_data = wr.data;

   wb_regfile u_rf (
      .clk (clk),
      .rst (rst),
      .wr  (wr),
      .ra1 (ra1),
      .ra2 (ra2),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fw_valid <= 1'b0;
         fw_addr  <= '0;
         fw_data  <= '0;
         wr_count <= '0;
      end else if (wr.we) begin
         fw_valid <= 1'b1;
         fw_addr  <= wr.addr;
         fw_data  <= wr.data;
         wr_count <= wr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, Result_in, dm_read_in;
   logic [4:0]  rt_in, rd_in, ra1, ra2;
   logic        RegDst_in, MemtoReg_in, RegWr_in, ExtopM_in, IsLink_in, IsByteW_in;
   logic [31:0] rd1, rd2, wb_data, fw_data;
   logic        wb_we, fw_valid;
   logic [4:0]  wb_addr, fw_addr;
   logic [31:0] wr_count;
   // Narrow-counter instance sharing the same inputs, used to observe wrap.
   logic [31:0] w_rd1, w_rd2, w_wb_data, w_fw_data;
   logic        w_wb_we, w_fw_valid;
   logic [4:0]  w_wb_addr, w_fw_addr;
   logic [2:0]  w_count;

   int nvec = 0;
   int nerr = 0;

   // Reference state
   logic [31:0] m_gpr [32];
   logic        m_fw_valid;
   logic [4:0]  m_fw_addr;
   logic [31:0] m_fw_data;
   longint      m_count;

   always #5 clk = ~clk;

   wb_stage #(.LINK_OFFSET(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .Result_in(Result_in), .dm_read_in(dm_read_in),
      .rt_in(rt_in), .rd_in(rd_in), .RegDst_in(RegDst_in), .MemtoReg_in(MemtoReg_in),
      .RegWr_in(RegWr_in), .ExtopM_in(ExtopM_in), .IsLink_in(IsLink_in), .IsByteW_in(IsByteW_in),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .fw_valid(fw_valid), .fw_addr(fw_addr), .fw_data(fw_data),
      .wr_count(wr_count));

   wb_stage #(.LINK_OFFSET(4), .CNT_W(3)) dut_wrap (
      .clk(clk), .rst(rst), .pc_in(pc_in), .Result_in(Result_in), .dm_read_in(dm_read_in),
      .rt_in(rt_in), .rd_in(rd_in), .RegDst_in(RegDst_in), .MemtoReg_in(MemtoReg_in),
      .RegWr_in(RegWr_in), .ExtopM_in(ExtopM_in), .IsLink_in(IsLink_in), .IsByteW_in(IsByteW_in),
      .ra1(ra1), .ra2(ra2), .rd1(w_rd1), .rd2(w_rd2), .wb_we(w_wb_we), .wb_addr(w_wb_addr),
      .wb_data(w_wb_data), .fw_valid(w_fw_valid), .fw_addr(w_fw_addr), .fw_data(w_fw_data),
      .wr_count(w_count));

   function automatic logic [4:0] ref_addr();
      if (IsLink_in) return 5'd31;
      return RegDst_in ? rd_in : rt_in;
   endfunction

   function automatic logic [31:0] ref_data();
      logic [31:0] b;
      if (IsLink_in) return pc_in + 32'd4;
      if (!MemtoReg_in) return Result_in;
      if (!IsByteW_in) return dm_read_in;
      b = (dm_read_in >> (8 * Result_in[1:0])) & 32'hFF;
      if (ExtopM_in && b >= 32'd128) b = b + 32'hFFFF_FF00;
      return b;
   endfunction

   task automatic idle();
      rst = 0; pc_in = 0; Result_in = 0; dm_read_in = 0; rt_in = 0; rd_in = 0;
      RegDst_in = 0; MemtoReg_in = 0; RegWr_in = 0; ExtopM_in = 0; IsLink_in = 0;
      IsByteW_in = 0; ra1 = 0; ra2 = 0;
   endtask

   task automatic test_reset();
      @(negedge clk); idle(); rst = 1;
      @(negedge clk); rst = 0; ra1 = 5; ra2 = 31;
      #1;
      nvec++; if (rd1 !== 32'd0) begin nerr++; $display("FAIL reset_rd1 got %h exp 0", rd1); end
      nvec++; if (rd2 !== 32'd0) begin nerr++; $display("FAIL reset_rd2 got %h exp 0", rd2); end
      nvec++; if (fw_valid !== 1'b0) begin nerr++; $display("FAIL reset_fw_valid got %b exp 0", fw_valid); end
      nvec++; if (wr_count !== 32'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", wr_count); end
   endtask

   task automatic test_byte_lanes();
      @(negedge clk); idle();
      dm_read_in = 32'h80FF_7F01; MemtoReg_in = 1; IsByteW_in = 1; ExtopM_in = 1; Result_in = 32'h3;
      #1;
      nvec++; if (wb_data !== 32'hFFFF_FF80) begin nerr++; $display("FAIL byte_lane3_sext got %h exp FFFFFF80", wb_data); end
      Result_in = 32'h1; ExtopM_in = 0;
      #1;
      nvec++; if (wb_data !== 32'h0000_007F) begin nerr++; $display("FAIL byte_lane1_zext got %h exp 0000007F", wb_data); end
      nvec++; if (wb_we !== 1'b0) begin nerr++; $display("FAIL byte_no_regwr_we got %b exp 0", wb_we); end
   endtask

   task automatic test_link();
      @(negedge clk); idle();
      IsLink_in = 1; MemtoReg_in = 1; RegWr_in = 1; pc_in = 32'h0040_0010; rt_in = 7;
      #1;
      nvec++; if (wb_addr !== 5'd31) begin nerr++; $display("FAIL link_addr got %0d exp 31", wb_addr); end
      nvec++; if (wb_data !== 32'h0040_0014) begin nerr++; $display("FAIL link_data got %h exp 00400014", wb_data); end
      @(posedge clk); #1;
      nvec++; if (fw_addr !== 5'd31) begin nerr++; $display("FAIL link_fw_addr got %0d exp 31", fw_addr); end
      nvec++; if (wr_count !== 32'd1) begin nerr++; $display("FAIL link_count got %0d exp 1", wr_count); end
   endtask

   task automatic test_zero_dest();
      @(negedge clk); idle();
      RegWr_in = 1; rt_in = 0; RegDst_in = 0; Result_in = 32'h1234_5678;
      #1;
      nvec++; if (wb_we !== 1'b0) begin nerr++; $display("FAIL zero_dest_we got %b exp 0", wb_we); end
      @(posedge clk); #1;
      nvec++; if (rd1 !== 32'd0) begin nerr++; $display("FAIL zero_dest_rd1 got %h exp 0", rd1); end
      nvec++; if (wr_count !== 32'd1) begin nerr++; $display("FAIL zero_dest_count got %0d exp 1", wr_count); end
   endtask

   task automatic test_bypass();
      @(negedge clk); idle();
      RegWr_in = 1; RegDst_in = 1; rd_in = 8; Result_in = 32'hDEAD_BEEF; ra1 = 8; ra2 = 8;
      #1;
      nvec++; if (rd1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL bypass_rd1 got %h exp DEADBEEF", rd1); end
      nvec++; if (rd2 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL bypass_rd2 got %h exp DEADBEEF", rd2); end
      @(negedge clk); RegWr_in = 0; Result_in = 32'h0;
      #1;
      nvec++; if (rd1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL stored_rd1 got %h exp DEADBEEF", rd1); end
   endtask

   task automatic test_reset_discard();
      @(negedge clk); idle();
      rst = 1; RegWr_in = 1; RegDst_in = 1; rd_in = 9; Result_in = 32'hCAFE_0009;
      #1;
      nvec++; if (wb_we !== 1'b0) begin nerr++; $display("FAIL rst_we got %b exp 0", wb_we); end
      @(negedge clk); idle(); ra1 = 9; ra2 = 8;
      #1;
      nvec++; if (rd1 !== 32'd0) begin nerr++; $display("FAIL rst_gpr9 got %h exp 0", rd1); end
      nvec++; if (rd2 !== 32'd0) begin nerr++; $display("FAIL rst_gpr8 got %h exp 0", rd2); end
      nvec++; if (wr_count !== 32'd0) begin nerr++; $display("FAIL rst_count got %0d exp 0", wr_count); end
      nvec++; if (fw_valid !== 1'b0) begin nerr++; $display("FAIL rst_fw_valid got %b exp 0", fw_valid); end
   endtask

   // Narrow counter: 8 commits after reset must bring it back to 0.
   task automatic test_wrap();
      @(negedge clk); idle(); rst = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); idle(); RegWr_in = 1; RegDst_in = 1; rd_in = 5'(i + 1); Result_in = i;
         @(posedge clk); #1;
         if (i == 6) begin
            nvec++; if (w_count !== 3'd7) begin nerr++; $display("FAIL wrap_pre got %0d exp 7", w_count); end
         end
      end
      nvec++; if (w_count !== 3'd0) begin nerr++; $display("FAIL wrap_zero got %0d exp 0", w_count); end
      nvec++; if (wr_count !== 32'd8) begin nerr++; $display("FAIL wrap_wide got %0d exp 8", wr_count); end
   endtask

   task automatic test_random(input int n);
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data, e_rd1, e_rd2;
      @(negedge clk); idle(); rst = 1;
      @(posedge clk);
      for (int r = 0; r < 32; r++) m_gpr[r] = 0;
      m_fw_valid = 0; m_fw_addr = 0; m_fw_data = 0; m_count = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst         = ($urandom_range(0, 39) == 0);
         pc_in       = $urandom & 32'hFFFF_FFFC;
         Result_in   = $urandom;
         dm_read_in  = $urandom;
         rt_in       = 5'($urandom);
         rd_in       = 5'($urandom);
         RegDst_in   = 1'($urandom);
         MemtoReg_in = 1'($urandom);
         RegWr_in    = ($urandom_range(0, 3) != 0);
         ExtopM_in   = 1'($urandom);
         IsLink_in   = ($urandom_range(0, 7) == 0);
         IsByteW_in  = 1'($urandom);
         e_addr = ref_addr();
         e_data = ref_data();
         e_we   = RegWr_in && e_addr != 0 && !rst;
         ra1 = ($urandom_range(0, 2) == 0) ? e_addr : 5'($urandom);
         ra2 = ($urandom_range(0, 2) == 0) ? e_addr : 5'($urandom);
         e_rd1 = (ra1 == 0) ? 32'd0 : (e_we && ra1 == e_addr) ? e_data : m_gpr[ra1];
         e_rd2 = (ra2 == 0) ? 32'd0 : (e_we && ra2 == e_addr) ? e_data : m_gpr[ra2];
         #1;
         nvec++; if (wb_we !== e_we) begin nerr++; $display("FAIL rnd_we[%0d] got %b exp %b", k, wb_we, e_we); end
         nvec++; if (wb_addr !== e_addr) begin nerr++; $display("FAIL rnd_addr[%0d] got %0d exp %0d", k, wb_addr, e_addr); end
         nvec++; if (wb_data !== e_data) begin nerr++; $display("FAIL rnd_data[%0d] got %h exp %h", k, wb_data, e_data); end
         nvec++; if (rd1 !== e_rd1) begin nerr++; $display("FAIL rnd_rd1[%0d] ra=%0d got %h exp %h", k, ra1, rd1, e_rd1); end
         nvec++; if (rd2 !== e_rd2) begin nerr++; $display("FAIL rnd_rd2[%0d] ra=%0d got %h exp %h", k, ra2, rd2, e_rd2); end
         @(posedge clk);
         if (rst) begin
            for (int r = 0; r < 32; r++) m_gpr[r] = 0;
            m_fw_valid = 0; m_fw_addr = 0; m_fw_data = 0; m_count = 0;
         end else if (e_we) begin
            m_gpr[e_addr] = e_data;
            m_fw_valid = 1; m_fw_addr = e_addr; m_fw_data = e_data; m_count++;
         end
         #1;
         nvec++; if (fw_valid !== m_fw_valid) begin nerr++; $display("FAIL rnd_fw_valid[%0d] got %b exp %b", k, fw_valid, m_fw_valid); end
         nvec++; if (fw_addr !== m_fw_addr) begin nerr++; $display("FAIL rnd_fw_addr[%0d] got %0d exp %0d", k, fw_addr, m_fw_addr); end
         nvec++; if (fw_data !== m_fw_data) begin nerr++; $display("FAIL rnd_fw_data[%0d] got %h exp %h", k, fw_data, m_fw_data); end
         nvec++; if (wr_count !== 32'(m_count)) begin nerr++; $display("FAIL rnd_count[%0d] got %0d exp %0d", k, wr_count, m_count); end
         nvec++; if (w_count !== 3'(m_count % 8)) begin nerr++; $display("FAIL rnd_wcount[%0d] got %0d exp %0d", k, w_count, m_count % 8); end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_byte_lanes();
      test_link();
      test_zero_dest();
      test_bypass();
      test_reset_discard();
      test_wrap();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
